// File: rtl/sha3_absorb_ctrl_if.sv
// ---------------------------------------------------------------------------
// sha3_absorb_ctrl_if
//
// Bundles every non-clock signal of the SHA3 absorb sequencer so the
// controller, the bus-side write logic and the Keccak core hookup share one
// definition.
//
// Signals:
//   in_valid / in_ready     message word handshake, transfer on both high
//   in_data[31:0]           message word, byte 0 in [7:0]
//   in_last                 final word of the message
//   in_nbytes[2:0]          valid bytes of the final word (0..4, 5..7 -> 4)
//   perm_start / perm_first start pulse to the permutation core, first-block flag
//   perm_block[575:0]       rate block, word k at [32k+31:32k]
//   perm_done               completion pulse from the permutation core
//   busy / done / err       controller status
//   block_cnt[CNT_W-1:0]    blocks issued for the current message
//
// Modports:
//   master  the environment: message source plus permutation core
//   slave   the sha3_absorb_ctrl sequencer
// ---------------------------------------------------------------------------
interface sha3_absorb_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic             in_last;
   logic [2:0]       in_nbytes;
   logic             perm_start;
   logic             perm_first;
   logic [575:0]     perm_block;
   logic             perm_done;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] block_cnt;

   modport master (
      output in_valid, in_data, in_last, in_nbytes, perm_done,
      input  in_ready, perm_start, perm_first, perm_block, busy, done, err, block_cnt
   );

   modport slave (
      input  in_valid, in_data, in_last, in_nbytes, perm_done,
      output in_ready, perm_start, perm_first, perm_block, busy, done, err, block_cnt
   );
endinterface

// File: rtl/sha3_absorb_ctrl.sv
// ---------------------------------------------------------------------------
// sha3_absorb_ctrl
//
// Absorb-path sequencer for SHA3. Collects 32-bit message words into a
// 576-bit (18-word) rate block, optionally appends the SHA3 pad10*1 padding
// with domain byte 0x06, and hands each block to the Keccak permutation core
// through a start/done handshake.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sha3_absorb_ctrl_if.slave: message stream in, permutation
//          handshake out, status (busy, done, err, block_cnt)
//
// Build option:
//   SHA3_PAD_EN  when defined, the final word is padded in hardware
//                (including the extra all-padding block when the message
//                fills the rate exactly). When undefined, the host supplies
//                fully padded blocks and a last word that does not close a
//                block raises err.
// ---------------------------------------------------------------------------
module sha3_absorb_ctrl #(
   parameter int RATE_WORDS = 18,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   sha3_absorb_ctrl_if.slave bus
);

   localparam int BLOCK_W    = RATE_WORDS * 32;
   localparam int RATE_BYTES = RATE_WORDS * 4;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
`ifdef SHA3_PAD_EN
      PAD,
`endif
      START,
      WAIT,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [BLOCK_W-1:0] block_q, block_d;
   logic [4:0]         wcnt_q, wcnt_d;
   logic               firstPend_q, firstPend_d;
   logic               finalPend_q, finalPend_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   blockCnt_q, blockCnt_d;
   logic               accept;
   logic [4:0]         idx;
   logic [9:0]         wordBase;
`ifdef SHA3_PAD_EN
   // Byte index inside the block where the 0x06 domain byte lands; a value of
   // RATE_BYTES means the message filled the block and padding spills over.
   logic [6:0]         padPos_q, padPos_d;
   logic               extraPend_q, extraPend_d;
   logic [2:0]         nbClamp;
`else
   logic               unusedNbytes;
   assign unusedNbytes = ^bus.in_nbytes;
`endif

   // Status and handshake outputs decode straight from the state register;
   // in_ready is also forced low while reset is held.
   assign bus.in_ready   = rst_n & ((state_q == IDLE) | (state_q == FILL));
   assign bus.perm_start = (state_q == START);
   assign bus.perm_first = (state_q == START) & firstPend_q;
   assign bus.perm_block = block_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == DONE);
   assign bus.err        = err_q;
   assign bus.block_cnt  = blockCnt_q;

   assign accept   = bus.in_valid & bus.in_ready;
   assign idx      = (state_q == IDLE) ? 5'd0 : wcnt_q;
   assign wordBase = {idx, 5'b00000};
`ifdef SHA3_PAD_EN
   assign nbClamp  = (bus.in_nbytes > 3'd4) ? 3'd4 : bus.in_nbytes;
`endif

   // Next-state logic: word capture, padding, block issue and status updates.
   // The block register is only written on an accepted word or in PAD, which
   // keeps perm_block stable for the whole START/WAIT window.
   always_comb begin
      state_d     = state_q;
      block_d     = block_q;
      wcnt_d      = wcnt_q;
      firstPend_d = firstPend_q;
      finalPend_d = finalPend_q;
      err_d       = err_q;
      blockCnt_d  = blockCnt_q;
`ifdef SHA3_PAD_EN
      padPos_d    = padPos_q;
      extraPend_d = extraPend_q;
`endif
      case (state_q)
         IDLE, FILL: begin
            if (accept) begin
               block_d[wordBase +: 32] = bus.in_data;
               if (state_q == IDLE) begin
                  err_d       = 1'b0;
                  blockCnt_d  = '0;
                  firstPend_d = 1'b1;
                  finalPend_d = 1'b0;
               end
               if (bus.in_last) begin
                  wcnt_d = 5'd0;
`ifdef SHA3_PAD_EN
                  padPos_d    = {idx, 2'b00} + {4'b0000, nbClamp};
                  finalPend_d = 1'b1;
                  state_d     = PAD;
`else
                  if (idx == 5'(RATE_WORDS - 1)) begin
                     finalPend_d = 1'b1;
                     state_d     = START;
                  end else begin
                     err_d       = 1'b1;
                     firstPend_d = 1'b0;
                     state_d     = IDLE;
                  end
`endif
               end else if (idx == 5'(RATE_WORDS - 1)) begin
                  wcnt_d  = 5'd0;
                  state_d = START;
               end else begin
                  wcnt_d  = idx + 5'd1;
                  state_d = FILL;
               end
            end
         end
`ifdef SHA3_PAD_EN
         // Bytes below padPos keep message data, padPos gets the domain byte
         // and everything above is cleared. The extra pad block reuses this
         // path with padPos=0, which yields 0x06 ... 0x80 on a blank block.
         PAD: begin
            for (int b = 0; b < RATE_BYTES; b++) begin
               if (7'(b) > padPos_q) begin
                  block_d[8*b +: 8] = 8'h00;
               end else if (7'(b) == padPos_q) begin
                  block_d[8*b +: 8] = 8'h06;
               end
            end
            extraPend_d = (padPos_q == 7'(RATE_BYTES));
            if (padPos_q != 7'(RATE_BYTES)) begin
               block_d[BLOCK_W-1] = 1'b1;
            end
            state_d = START;
         end
`endif
         START: begin
            if (blockCnt_q != {CNT_W{1'b1}}) begin
               blockCnt_d = blockCnt_q + 1'b1;
            end
            firstPend_d = 1'b0;
            state_d     = WAIT;
         end
         WAIT: begin
            if (bus.perm_done) begin
`ifdef SHA3_PAD_EN
               if (extraPend_q) begin
                  padPos_d = 7'd0;
                  state_d  = PAD;
               end else
`endif
               if (finalPend_q) begin
                  state_d = DONE;
               end else begin
                  wcnt_d  = 5'd0;
                  state_d = FILL;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with asynchronous clear of every flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         block_q     <= '0;
         wcnt_q      <= 5'd0;
         firstPend_q <= 1'b0;
         finalPend_q <= 1'b0;
         err_q       <= 1'b0;
         blockCnt_q  <= '0;
`ifdef SHA3_PAD_EN
         padPos_q    <= 7'd0;
         extraPend_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         block_q     <= block_d;
         wcnt_q      <= wcnt_d;
         firstPend_q <= firstPend_d;
         finalPend_q <= finalPend_d;
         err_q       <= err_d;
         blockCnt_q  <= blockCnt_d;
`ifdef SHA3_PAD_EN
         padPos_q    <= padPos_d;
         extraPend_q <= extraPend_d;
`endif
      end
   end

endmodule

// File: doc/sha3_absorb_ctrl.md
# sha3_absorb_ctrl

Sequencer for the SHA3 absorb path. Accepts the 32-bit message stream from the bus-side write logic, assembles 576-bit rate blocks (18 words), optionally applies SHA3 pad10*1, and issues each block to the Keccak permutation core with a start/done handshake. Sits between the user-project bus interface and the permutation core, replacing software-driven block loading.

## Interface
- `RATE_WORDS`, 18: words per rate block. Fixed at 18; the block width is 576.
- `CNT_W`, 16: width of `block_cnt`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  message word valid.
- `in_ready`  out  1  controller accepts a word; transfer when `in_valid & in_ready`.
- `in_data`  in  32  message word, little-endian bytes: byte 0 is `[7:0]`.
- `in_last`  in  1  word is the final word of the message.
- `in_nbytes`  in  3  valid bytes in the last word, 0..4. Ignored unless `in_last`. Values 5..7 are treated as 4.
- `perm_start`  out  1  one-cycle pulse: `perm_block` is ready for absorption.
- `perm_first`  out  1  qualifies `perm_start`: first block of a message, so the core clears its state.
- `perm_block`  out  576  block register; word k sits at `[32k+31:32k]`.
- `perm_done`  in  1  one-cycle pulse from the core: permutation finished.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse: final block of the message has been permuted.
- `err`  out  1  sticky protocol error.
- `block_cnt`  out  CNT_W  blocks issued for the current message; saturates at all-ones.

## Operation
- States: IDLE, FILL, PAD, START, WAIT, DONE.
- **IDLE:**
  - `in_ready=1`.
  - On accept: `err` clears, `block_cnt` clears, `first_pend` is set, the word is written to word 0, the word counter becomes 1, and the FSM goes to FILL (or to last-word handling, below).
- **FILL:**
  - `in_ready=1`.
  - Each accept writes `in_data` to word `wcnt` and increments `wcnt`.
  - A non-last accept at `wcnt==17` goes to START, and `wcnt` wraps to 0.
- **Last-word handling with `SHA3_PAD_EN`:**
  - Any accept with `in_last` records `n=in_nbytes` and the word index `k`, then goes to PAD.
- **PAD (single cycle):**
  - Word k: bytes `n..3` are zeroed. If `n<4`, byte n is set to `0x06`.
  - Words `k+1..17` are zeroed.
  - If `n==4` and `k<17`, byte 0 of word k+1 is set to `0x06`.
  - If `n==4` and `k==17`, `extra_pend` is set and no `0x06` is written in this block.
  - Bit 575 is ORed with 1 (byte `0x80`) unless `extra_pend` was just set.
  - Next state: START.
- **Extra pad block:** on WAIT exit with `extra_pend`, PAD loads an all-zero block with byte 0 set to `0x06` and bit 575 set, clears `extra_pend`, then goes to START.
- **START (one cycle):**
  - `perm_start=1` and `perm_first=first_pend`.
  - `block_cnt` increments (saturating).
  - `first_pend` clears. Next state: WAIT.
- **WAIT:**
  - `in_ready=0`; `perm_block` is held stable.
  - On `perm_done`, the next state is:
    - PAD if `extra_pend`;
    - DONE if the message is complete;
    - FILL otherwise, with `wcnt=0`.
- **DONE:** `done=1` for one cycle, then IDLE.
- `perm_done` outside WAIT is ignored.
- **Without `SHA3_PAD_EN`:**
  - `in_last` at `wcnt==17` goes directly to START as the final block.
  - `in_last` at `wcnt<17` sets `err`, discards the block, clears `first_pend`, and returns to IDLE without issuing `perm_start`.
- **Reset:** asynchronous; all outputs and state go to zero immediately, including mid-WAIT. A `perm_done` arriving after reset is ignored.
- **Reset values:** `in_ready=0` while `rst_n=0`, then 1 (IDLE). `perm_start=0`, `perm_first=0`, `perm_block=0`, `busy=0`, `done=0`, `err=0`, `block_cnt=0`.

## Timing
- Accept of the 18th non-last word at cycle N → `perm_start` at N+1.
- With `SHA3_PAD_EN`, accept of a last word at cycle N → PAD at N+1 → `perm_start` at N+2.
- `perm_done` at cycle M → `done` at M+1 (final block), `in_ready=1` at M+1 (FILL), or PAD at M+1 (extra block).
- `perm_block` is stable from the START cycle until the cycle after `perm_done`.
- Sustained input rate: 1 word/cycle while in FILL.

## Configuration
- `SHA3_PAD_EN` defined: hardware pad10*1 with domain byte `0x06`, including the extra-block case, as described above. `in_nbytes` is honoured.
- `SHA3_PAD_EN` undefined: no PAD state. The host supplies fully padded blocks; `in_nbytes` is ignored; a misaligned `in_last` raises `err`.

## Test plan
- No pad: 18 words `0x00000001..0x00000012`, `in_last` on word 18 → `perm_start` one cycle later with `perm_first=1`, `perm_block[31:0]=1`, `perm_block[575:544]=0x12`; `perm_done` → `done` next cycle, `block_cnt=1`.
- Pad: 3 words `0xAABBCCDD`, `0x11223344`, `0x5566` with `in_nbytes=2` → word2 = `0x00065566`, words 3..17 zero, bit 575 = 1, `perm_start` two cycles after the last accept.
- Pad, empty message: single word with `in_last`, `in_nbytes=0` → word0 = `0x00000006`, word17 = `0x80000000`, `block_cnt=1`.
- Pad, aligned: 18 words with `in_nbytes=4` on the last → two `perm_start` pulses (second with `perm_first=0`); second block word0 = `0x06`, word17 = `0x80000000`; `block_cnt=2`; `done` once.
- Backpressure: `in_valid` held high through WAIT → `in_ready=0` until the cycle after `perm_done`; no word lost or duplicated across a 2-block message.
- `rst_n` low mid-WAIT, then `perm_done` → all outputs 0, no `done`; a fresh message afterwards has `perm_first=1`. Without `SHA3_PAD_EN`, `in_last` on word 5 → `err=1`, no `perm_start`, IDLE.
